// File: rtl/plru_pkg.sv
// Purpose: shared types and helpers for the tree pseudo-LRU replacement engine.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
// Contents: tree_t working register (widest tree), state_t FSM encoding, clog2.
package plru_pkg;

    // Widest supported associativity; narrower trees use the low WAYS-1 bits.
    localparam int MAX_WAYS = 32;

    typedef logic [MAX_WAYS-2:0] tree_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Purpose: combinational tree-PLRU helpers: victim walk and access update for one set.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
// Ports: tree_in/way_in (current tree, accessed way) -> tree_out (tree after access),
//        victim (way the tree points at for tree_in).
module plru_tree_logic
    import plru_pkg::*;
#(
    parameter int WAYS  = 8,
    parameter int WAY_W = clog2(WAYS)
) (
    input  logic [WAYS-2:0]  tree_in,
    input  logic [WAY_W-1:0] way_in,
    output logic [WAYS-2:0]  tree_out,
    output logic [WAY_W-1:0] victim
);

    // Walk from the root; a 0 bit sends the victim into the lower half.
    // Node indices are kept 5 bits wide, enough for the widest tree.
    function automatic logic [WAY_W-1:0] tree_victim(input logic [WAYS-2:0] tree);
        tree_t            t;
        logic [4:0]       n;
        logic             b;
        logic [WAY_W-1:0] w;
        t = '0;
        t[WAYS-2:0] = tree;
        n = '0;
        w = '0;
        for (int l = 0; l < WAY_W; l++) begin
            b = t[n];
            w = (w << 1) | WAY_W'(b);
            n = {n[3:0], 1'b1} + 5'(b);
        end
        return w;
    endfunction

    // Each node on the path is pointed away from the accessed way: 1 when the
    // way sits in the node's lower half, 0 when it sits in the upper half.
    function automatic logic [WAYS-2:0] tree_touch(input logic [WAYS-2:0]  tree,
                                                    input logic [WAY_W-1:0] way);
        tree_t            t;
        logic [4:0]       n;
        logic             b;
        logic [WAY_W-1:0] w;
        t = '0;
        t[WAYS-2:0] = tree;
        n = '0;
        w = way;
        for (int l = 0; l < WAY_W; l++) begin
            b = w[WAY_W-1];
            t[n] = ~b;
            n = {n[3:0], 1'b1} + 5'(b);
            w = w << 1;
        end
        return t[WAYS-2:0];
    endfunction

    assign tree_out = tree_touch(tree_in, way_in);
    assign victim   = tree_victim(tree_in);

endmodule

// File: rtl/cache_plru_tree.sv
// Purpose: per-set tree pseudo-LRU engine with two hit streams and a held victim output.
// Latency: request to repl_way_valid is 1 cycle; hit updates land the following cycle.
// Backpressure: victim is held (stable) until repl_ready; requests are only taken in IDLE.
// Ports: clock/reset/flush; hit_rd_* and hit_wr_* update strobes; repl_req/repl_index/
//        repl_line_valid request; repl_ready accept; repl_way_valid/repl_way/repl_busy out.
module cache_plru_tree
    import plru_pkg::*;
#(
    parameter int WAYS             = 8,
    parameter int SETS             = 64,
    parameter int IDX_W            = clog2(SETS),
    parameter int WAY_W            = clog2(WAYS),
    parameter bit TOUCH_ON_REPLACE = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             hit_rd_valid,
    input  logic [IDX_W-1:0] hit_rd_index,
    input  logic [WAY_W-1:0] hit_rd_way,
    input  logic             hit_wr_valid,
    input  logic [IDX_W-1:0] hit_wr_index,
    input  logic [WAY_W-1:0] hit_wr_way,
    input  logic             repl_req,
    input  logic [IDX_W-1:0] repl_index,
    input  logic [WAYS-1:0]  repl_line_valid,
    input  logic             repl_ready,
    output logic             repl_way_valid,
    output logic [WAY_W-1:0] repl_way,
    output logic             repl_busy
);

    logic [WAYS-2:0]  tree_q [SETS];
    state_t           state_q, state_d;
    logic [WAY_W-1:0] held_way_q;
    logic [IDX_W-1:0] held_idx_q;

    logic [WAYS-2:0]  rd_tree, wr_base, wr_tree, rp_base, rp_tree;
    logic [WAY_W-1:0] tree_vict, inv_way, victim_way;
    logic             inv_found, touch_en, capture;

    logic [WAY_W-1:0] victim_unused_rd, victim_unused_wr, victim_unused_rp;
    logic [WAYS-2:0]  tree_unused_vs;

    // Same-set updates in one cycle are chained (read, then write, then
    // replace touch) so the last writer carries every earlier update.
    assign wr_base = (hit_rd_valid && hit_rd_index == hit_wr_index) ? rd_tree
                                                                    : tree_q[hit_wr_index];
    always_comb begin
        rp_base = tree_q[held_idx_q];
        if (hit_wr_valid && hit_wr_index == held_idx_q) begin
            rp_base = wr_tree;
        end else if (hit_rd_valid && hit_rd_index == held_idx_q) begin
            rp_base = rd_tree;
        end
    end

    plru_tree_logic #(.WAYS(WAYS), .WAY_W(WAY_W)) u_upd_rd (
        .tree_in (tree_q[hit_rd_index]),
        .way_in  (hit_rd_way),
        .tree_out(rd_tree),
        .victim  (victim_unused_rd)
    );

    plru_tree_logic #(.WAYS(WAYS), .WAY_W(WAY_W)) u_upd_wr (
        .tree_in (wr_base),
        .way_in  (hit_wr_way),
        .tree_out(wr_tree),
        .victim  (victim_unused_wr)
    );

    plru_tree_logic #(.WAYS(WAYS), .WAY_W(WAY_W)) u_upd_rp (
        .tree_in (rp_base),
        .way_in  (held_way_q),
        .tree_out(rp_tree),
        .victim  (victim_unused_rp)
    );

    // Victim is taken from the registered state, i.e. before this cycle's hits.
    plru_tree_logic #(.WAYS(WAYS), .WAY_W(WAY_W)) u_victim (
        .tree_in (tree_q[repl_index]),
        .way_in  ('0),
        .tree_out(tree_unused_vs),
        .victim  (tree_vict)
    );

    // Lowest-numbered invalid way wins; descending loop leaves the lowest hit.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!repl_line_valid[i]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(i);
            end
        end
    end

    assign victim_way = inv_found ? inv_way : tree_vict;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (repl_req)   state_d = ST_HOLD;
            ST_HOLD: if (repl_ready) state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    assign capture  = (state_q == ST_IDLE) && repl_req && !flush;
    assign touch_en = TOUCH_ON_REPLACE && (state_q == ST_HOLD) && repl_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            held_way_q <= '0;
            held_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                held_way_q <= victim_way;
                held_idx_q <= repl_index;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
        end else begin
            if (hit_rd_valid) tree_q[hit_rd_index] <= rd_tree;
            if (hit_wr_valid) tree_q[hit_wr_index] <= wr_tree;
            if (touch_en)     tree_q[held_idx_q]   <= rp_tree;
        end
    end

    assign repl_way_valid = (state_q == ST_HOLD);
    assign repl_busy      = (state_q == ST_HOLD);
    assign repl_way       = held_way_q;

endmodule

// File: tb/tb_cache_plru_tree.sv
// Purpose: self-checking bench for cache_plru_tree (WAYS=8, SETS=64, touch on replace).
// Latency: model expects the victim one cycle after the request.
// Backpressure: bench only raises repl_req while no victim is held.
module tb_cache_plru_tree;

    localparam int WAYS  = 8;
    localparam int SETS  = 64;
    localparam int IDX_W = 6;
    localparam int WAY_W = 3;

    logic             clock;
    logic             reset;
    logic             flush;
    logic             hit_rd_valid;
    logic [IDX_W-1:0] hit_rd_index;
    logic [WAY_W-1:0] hit_rd_way;
    logic             hit_wr_valid;
    logic [IDX_W-1:0] hit_wr_index;
    logic [WAY_W-1:0] hit_wr_way;
    logic             repl_req;
    logic [IDX_W-1:0] repl_index;
    logic [WAYS-1:0]  repl_line_valid;
    logic             repl_ready;
    logic             repl_way_valid;
    logic [WAY_W-1:0] repl_way;
    logic             repl_busy;

    cache_plru_tree #(
        .WAYS(WAYS), .SETS(SETS), .IDX_W(IDX_W), .WAY_W(WAY_W), .TOUCH_ON_REPLACE(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .hit_rd_valid(hit_rd_valid), .hit_rd_index(hit_rd_index), .hit_rd_way(hit_rd_way),
        .hit_wr_valid(hit_wr_valid), .hit_wr_index(hit_wr_index), .hit_wr_way(hit_wr_way),
        .repl_req(repl_req), .repl_index(repl_index), .repl_line_valid(repl_line_valid),
        .repl_ready(repl_ready), .repl_way_valid(repl_way_valid), .repl_way(repl_way),
        .repl_busy(repl_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp;
    int n_err;

    // Reference model: per-way time of last access (0 = never since clear).
    // A node points away from whichever half holds the most recent access in
    // its subtree; an untouched subtree points to its lower half.
    longint ts [SETS][WAYS];
    longint now;
    bit     m_hold;
    int     m_way;
    int     m_idx;

    function automatic int tree_pick(int s);
        int     lo, sz, half;
        longint ml, mu;
        lo = 0;
        sz = WAYS;
        while (sz > 1) begin
            half = sz / 2;
            ml = 0;
            mu = 0;
            for (int i = 0; i < half; i++) begin
                if (ts[s][lo+i] > ml) ml = ts[s][lo+i];
                if (ts[s][lo+half+i] > mu) mu = ts[s][lo+half+i];
            end
            if (ml > mu) lo = lo + half;
            sz = half;
        end
        return lo;
    endfunction

    function automatic int m_victim(int s, logic [WAYS-1:0] lv);
        for (int i = 0; i < WAYS; i++) begin
            if (!lv[i]) return i;
        end
        return tree_pick(s);
    endfunction

    task automatic m_touch(int s, int w);
        now = now + 1;
        ts[s][w] = now;
    endtask

    task automatic m_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                ts[s][w] = 0;
        m_hold = 1'b0;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one cycle from the currently driven inputs, clock
    // the DUT, then compare its outputs against the model.
    task automatic cycle();
        int v;
        v = 0;
        if (reset || flush) begin
            m_clear();
        end else begin
            if (!m_hold && repl_req) v = m_victim(int'(repl_index), repl_line_valid);
            if (hit_rd_valid) m_touch(int'(hit_rd_index), int'(hit_rd_way));
            if (hit_wr_valid) m_touch(int'(hit_wr_index), int'(hit_wr_way));
            if (m_hold && repl_ready) begin
                m_touch(m_idx, m_way);
                m_hold = 1'b0;
            end else if (!m_hold && repl_req) begin
                m_hold = 1'b1;
                m_way  = v;
                m_idx  = int'(repl_index);
            end
        end
        @(posedge clock);
        #1;
        check("valid", 32'(repl_way_valid), 32'(m_hold));
        check("busy", 32'(repl_busy), 32'(m_hold));
        if (m_hold) check("held_way", 32'(repl_way), 32'(m_way));
    endtask

    task automatic idle_inputs();
        flush           = 1'b0;
        hit_rd_valid    = 1'b0;
        hit_rd_index    = '0;
        hit_rd_way      = '0;
        hit_wr_valid    = 1'b0;
        hit_wr_index    = '0;
        hit_wr_way      = '0;
        repl_req        = 1'b0;
        repl_index      = '0;
        repl_line_valid = '1;
        repl_ready      = 1'b0;
    endtask

    task automatic request(int s, logic [WAYS-1:0] lv);
        repl_index      = IDX_W'(s);
        repl_line_valid = lv;
        repl_req        = 1'b1;
        cycle();
        repl_req        = 1'b0;
        repl_line_valid = '1;
    endtask

    task automatic accept();
        repl_ready = 1'b1;
        cycle();
        repl_ready = 1'b0;
    endtask

    task automatic hit_rd(int s, int w);
        hit_rd_valid = 1'b1;
        hit_rd_index = IDX_W'(s);
        hit_rd_way   = WAY_W'(w);
        cycle();
        hit_rd_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        now   = 0;
        m_way = 0;
        m_idx = 0;
        m_clear();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", 32'(repl_way_valid), 32'd0);
        check("rst_busy", 32'(repl_busy), 32'd0);
        check("rst_way", 32'(repl_way), 32'd0);
        reset = 1'b0;

        // Fresh tree on set 5 points at way 0.
        request(5, 8'hFF);
        check("first_way", 32'(repl_way), 32'd0);
        accept();
        check("accept_drop", 32'(repl_way_valid), 32'd0);

        // Read hit on way 0 sends the victim to the upper half.
        hit_rd(5, 0);
        request(5, 8'hFF);
        check("after_hit0", 32'(repl_way), 32'd4);
        accept();

        // Hits 0,4,2,6 on set 3 leave way 1 as victim; set 4 untouched.
        hit_rd(3, 0);
        hit_rd(3, 4);
        hit_rd(3, 2);
        hit_rd(3, 6);
        request(3, 8'hFF);
        check("set3_way", 32'(repl_way), 32'd1);
        accept();
        request(4, 8'hFF);
        check("set4_way", 32'(repl_way), 32'd0);
        accept();

        // Invalid way overrides the tree.
        request(3, 8'b1110_1111);
        check("invalid_pri", 32'(repl_way), 32'd4);
        accept();

        // Read and write hit on one set in one cycle: write applied last.
        hit_rd_valid = 1'b1; hit_rd_index = 6'd9; hit_rd_way = 3'd0;
        hit_wr_valid = 1'b1; hit_wr_index = 6'd9; hit_wr_way = 3'd7;
        cycle();
        idle_inputs();
        request(9, 8'hFF);
        check("rd_wr_same", 32'(repl_way), 32'd2);
        accept();

        // Held victim stays put while the set is hit; touch shows on next request.
        request(5, 8'hFF);
        check("hold_cap", 32'(repl_way), 32'd2);
        for (int k = 0; k < 3; k++) begin
            hit_rd(5, 0);
            check("hold_stable", 32'(repl_way), 32'd2);
        end
        accept();
        check("hold_drop", 32'(repl_way_valid), 32'd0);
        request(5, 8'hFF);
        check("after_touch", 32'(repl_way), 32'd6);
        accept();

        // Flush during HOLD clears everything.
        request(9, 8'hFF);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_drop", 32'(repl_way_valid), 32'd0);
        request(3, 8'hFF);
        check("flush_s3", 32'(repl_way), 32'd0);
        accept();
        request(5, 8'hFF);
        check("flush_s5", 32'(repl_way), 32'd0);
        accept();
        request(9, 8'hFF);
        check("flush_s9", 32'(repl_way), 32'd0);
        accept();

        // Asynchronous reset in HOLD drops valid without a clock edge.
        hit_rd(7, 1);
        request(7, 8'hFF);
        reset = 1'b1;
        #2;
        check("arst_valid", 32'(repl_way_valid), 32'd0);
        check("arst_busy", 32'(repl_busy), 32'd0);
        check("arst_way", 32'(repl_way), 32'd0);
        cycle();
        reset = 1'b0;
        cycle();

        // Randomised traffic, concentrated on a few sets to force collisions.
        for (int k = 0; k < 3000; k++) begin
            hit_rd_valid    = 1'($urandom_range(0, 1));
            hit_rd_index    = IDX_W'($urandom_range(0, 7));
            hit_rd_way      = WAY_W'($urandom_range(0, 7));
            hit_wr_valid    = 1'($urandom_range(0, 1));
            hit_wr_index    = IDX_W'($urandom_range(0, 7));
            hit_wr_way      = WAY_W'($urandom_range(0, 7));
            repl_req        = !m_hold && ($urandom_range(0, 2) == 0);
            repl_index      = ($urandom_range(0, 3) == 0) ? IDX_W'($urandom_range(0, 63))
                                                          : IDX_W'($urandom_range(0, 7));
            repl_line_valid = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            repl_ready      = 1'($urandom_range(0, 1));
            flush           = ($urandom_range(0, 63) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
